// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N -> 2**N one-hot decoder with direct and auto-scan modes.
// Define DECODER_SCAN_BIDIR_EN to add the Dir input for downward scanning.
module decoder_n_scan #(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               E,
  input  logic               Mode,
`ifdef DECODER_SCAN_BIDIR_EN
  input  logic               Dir,
`endif
  input  logic [N-1:0]       In,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [DWELL_W-1:0] Dwell,
  output logic [2**N-1:0]    Out,
  output logic               Out_valid,
  output logic [N-1:0]       Code,
  output logic               Wrap
);

  localparam int OW = 2**N;
  localparam logic [OW-1:0] ONE = OW'(1);

  logic [OW-1:0]      out_q, out_d;
  logic               vld_q, vld_d;
  logic [N-1:0]       code_q, code_d;
  logic               wrap_q, wrap_d;
  logic [N-1:0]       scan_q, scan_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwl_q, dwl_d;
  logic               mode_q;

  logic               xfer;
  logic               mode_chg;
  logic               dwell_end;
  logic               dir_dn;
  logic [N-1:0]       nxt;
  logic [N-1:0]       wrap_pt;

  assign In_ready  = E & ~Mode & ~rst;
  assign xfer      = In_valid & In_ready;
  assign mode_chg  = Mode ^ mode_q;
  assign dwell_end = (cnt_q == dwl_q);

`ifdef DECODER_SCAN_BIDIR_EN
  assign dir_dn = Dir;
`else
  assign dir_dn = 1'b0;
`endif

  assign nxt     = dir_dn ? (scan_q - 1'b1) : (scan_q + 1'b1);
  assign wrap_pt = dir_dn ? '1 : '0;

  // vld_q low in scan mode means entry or resume: present scan_q fresh
  always_comb begin
    out_d  = out_q;
    vld_d  = vld_q;
    code_d = code_q;
    wrap_d = 1'b0;
    scan_d = scan_q;
    cnt_d  = cnt_q;
    dwl_d  = dwl_q;
    if (!E) begin
      out_d = '0;
      vld_d = 1'b0;
    end else if (mode_chg) begin
      out_d = '0;
      vld_d = 1'b0;
      cnt_d = '0;
      if (Mode) scan_d = '0;
    end else if (!Mode) begin
      if (xfer) begin
        out_d  = ONE << In;
        vld_d  = 1'b1;
        code_d = In;
      end
    end else if (!vld_q) begin
      out_d  = ONE << scan_q;
      vld_d  = 1'b1;
      code_d = scan_q;
      cnt_d  = '0;
      dwl_d  = Dwell;
    end else if (dwell_end) begin
      scan_d = nxt;
      out_d  = ONE << nxt;
      code_d = nxt;
      cnt_d  = '0;
      dwl_d  = Dwell;
      wrap_d = (nxt == wrap_pt);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= Mode;
    if (rst) begin
      out_q  <= '0;
      vld_q  <= 1'b0;
      code_q <= '0;
      wrap_q <= 1'b0;
      scan_q <= '0;
      cnt_q  <= '0;
      dwl_q  <= '0;
    end else begin
      out_q  <= out_d;
      vld_q  <= vld_d;
      code_q <= code_d;
      wrap_q <= wrap_d;
      scan_q <= scan_d;
      cnt_q  <= cnt_d;
      dwl_q  <= dwl_d;
    end
  end

  assign Out       = out_q;
  assign Out_valid = vld_q;
  assign Code      = code_q;
  assign Wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// tb_decoder_n_scan: table vectors, directed scan sequences and
// randomized stimulus against a behavioural model of decoder_n_scan.
module tb_decoder_n_scan;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int OW = 8;
  localparam int SZ = 8;

  logic          clk = 1'b0;
  logic          rst, E, Mode, In_valid;
  logic          In_ready, Out_valid, Wrap;
  logic [N-1:0]  In, Code;
  logic [DW-1:0] Dwell;
  logic [OW-1:0] Out;
`ifdef DECODER_SCAN_BIDIR_EN
  logic          Dir;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_n_scan #(.N(N), .DWELL_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .E(E),
    .Mode(Mode),
`ifdef DECODER_SCAN_BIDIR_EN
    .Dir(Dir),
`endif
    .In(In),
    .In_valid(In_valid),
    .In_ready(In_ready),
    .Dwell(Dwell),
    .Out(Out),
    .Out_valid(Out_valid),
    .Code(Code),
    .Wrap(Wrap)
  );

  // reference model: shown code (-1 = blank), cycles left in dwell
  int m_show = -1;
  int m_code = 0;
  int m_scan = 0;
  int m_left = 0;
  int m_wrap = 0;
  int m_pmode = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    bit down;
`ifdef DECODER_SCAN_BIDIR_EN
    down = Dir;
`else
    down = 1'b0;
`endif
    if (rst) begin
      m_show = -1; m_code = 0; m_wrap = 0;
      m_scan = 0; m_left = 0;
    end else if (!E) begin
      m_show = -1; m_wrap = 0;
    end else if (int'(Mode) != m_pmode) begin
      m_show = -1; m_wrap = 0; m_left = 0;
      if (Mode) m_scan = 0;
    end else if (!Mode) begin
      m_wrap = 0;
      if (In_valid) begin
        m_show = int'(In); m_code = int'(In);
      end
    end else if (m_show < 0) begin
      m_show = m_scan; m_code = m_scan;
      m_left = int'(Dwell); m_wrap = 0;
    end else if (m_left == 0) begin
      m_scan = down ? (m_scan + SZ - 1) % SZ : (m_scan + 1) % SZ;
      m_show = m_scan; m_code = m_scan;
      m_left = int'(Dwell);
      m_wrap = (m_scan == (down ? SZ - 1 : 0)) ? 1 : 0;
    end else begin
      m_left--; m_wrap = 0;
    end
    m_pmode = int'(Mode);
  endtask

  task automatic step();
    logic [63:0] eo;
    #1;
    chk("in_ready", In_ready, E & ~Mode & ~rst);
    @(posedge clk);
    model_update();
    @(negedge clk);
    eo = (m_show < 0) ? 64'd0 : (64'd1 << m_show);
    chk("m_out", Out, eo);
    chk("m_vld", Out_valid, m_show >= 0);
    chk("m_code", Code, m_code);
    chk("m_wrap", Wrap, m_wrap);
    chk("onehot", ($onehot0(Out) && (!Out_valid || $onehot(Out))), 1);
  endtask

  task automatic see(input string nm, input int c, input bit w);
    chk({nm, "_code"}, Code, c);
    chk({nm, "_out"}, Out, 64'd1 << c);
    chk({nm, "_vld"}, Out_valid, 1);
    chk({nm, "_wrap"}, Wrap, w);
  endtask

  task automatic blank(input string nm);
    chk({nm, "_out"}, Out, 0);
    chk({nm, "_vld"}, Out_valid, 0);
  endtask

  typedef struct {
    logic       r, e, m, iv;
    logic [2:0] in;
    logic [3:0] dw;
    logic [7:0] out;
    logic       vld;
    logic [2:0] code;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit m, bit iv, int in, int dw,
                              int out, bit vld, int code, bit wrap);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.iv = iv;
    v.in = 3'(in); v.dw = 4'(dw);
    v.out = 8'(out); v.vld = vld; v.code = 3'(code); v.wrap = wrap;
    return v;
  endfunction

  initial begin
    rst = 1; E = 0; Mode = 0; In = 0; In_valid = 0; Dwell = 0;
`ifdef DECODER_SCAN_BIDIR_EN
    Dir = 0;
`endif
    @(negedge clk);

    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 8'h00, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 0, 1, i, 2, 1 << i, 1, i, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 2, 8'h80, 1, 7, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 2, 8'h00, 0, 7, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 2, 8'h00, 0, 7, 0));
    tbl.push_back(mk(0, 1, 1, 1, 3, 2, 8'h00, 0, 7, 0));
    tbl.push_back(mk(0, 1, 1, 1, 3, 2, 8'h01, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 3, 2, 8'h01, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3, 2, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3, 2, 8'h08, 1, 3, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].r; E = tbl[i].e; Mode = tbl[i].m;
      In_valid = tbl[i].iv; In = tbl[i].in; Dwell = tbl[i].dw;
      step();
      chk($sformatf("tbl%0d_out", i), Out, tbl[i].out);
      chk($sformatf("tbl%0d_vld", i), Out_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_code", i), Code, tbl[i].code);
      chk($sformatf("tbl%0d_wrap", i), Wrap, tbl[i].wrap);
    end

    // scan timing: Dwell=2, period 24, code 0 right after reset
    rst = 1; E = 1; Mode = 1; In_valid = 0; Dwell = 2;
    step();
    blank("scan_rst");
    rst = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      see("scan", (k / 3) % 8, (k > 0) && (k % 24 == 0));
    end

    // pause at code 5, then resume with a full dwell
    rst = 1; step(); rst = 0;
    for (int k = 0; k < 16; k++) step();
    see("pre_pause", 5, 0);
    E = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      blank("pause");
      chk("pause_code", Code, 5);
    end
    E = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      see("resume", 5, 0);
    end
    step();
    see("resume_next", 6, 0);

    // reset mid-scan at code 6
    rst = 1; step();
    blank("midrst");
    chk("midrst_code", Code, 0);
    chk("midrst_wrap", Wrap, 0);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      see("restart", 0, 0);
    end
    step();
    see("restart_next", 1, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      E = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 39) == 0) Mode = ~Mode;
      In = 3'($urandom);
      In_valid = 1'($urandom);
      if ($urandom_range(0, 7) == 0) Dwell = 4'($urandom_range(0, 3));
`ifdef DECODER_SCAN_BIDIR_EN
      if ($urandom_range(0, 29) == 0) Dir = ~Dir;
`endif
      step();
    end

`ifdef DECODER_SCAN_BIDIR_EN
    rst = 1; E = 1; Mode = 1; Dwell = 0; Dir = 1; In_valid = 0;
    step();
    rst = 0;
    for (int k = 0; k < 18; k++) begin
      step();
      see("down", (8 - (k % 8)) % 8, (k % 8) == 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_n_scan.md
DECODER_N_SCAN -- requirements
Module: decoder_n_scan

Interface
REQ-001 SHALL have parameter N, default 3, meaning code width; output width is 2**N; legal range 1..6.
REQ-002 SHALL have parameter DWELL_W, default 4, meaning width of the dwell setting.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port E  input  1  block enable.
REQ-006 SHALL have port Mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 SHALL have port In  input  N  code to decode in direct mode.
REQ-008 SHALL have port In_valid  input  1  In carries a request.
REQ-009 SHALL have port In_ready  output  1  block accepts In this cycle.
REQ-010 SHALL have port Dwell  input  DWELL_W  scan hold time minus one, in cycles.
REQ-011 SHALL have port Out  output  2**N  registered one-hot decode result.
REQ-012 SHALL have port Out_valid  output  1  Out holds a valid one-hot value.
REQ-013 SHALL have port Code  output  N  binary code currently presented on Out.
REQ-014 SHALL have port Wrap  output  1  one-cycle pulse when the scan wraps.

Function
REQ-015 SHALL drive In_ready = E & ~Mode & ~rst (combinational); a transfer occurs when In_valid & In_ready.
REQ-016 SHALL, in direct mode, register Out = 1<<In, Code = In and Out_valid = 1 on the edge after a transfer (latency 1 cycle).
REQ-017 SHALL hold Out, Code and Out_valid unchanged in direct mode when there is no transfer.
REQ-018 SHALL, in scan mode, keep an internal scan code and a dwell counter.
REQ-019 SHALL present Out = 1<<scan code with Out_valid = 1 for exactly Dwell+1 cycles per code, then advance the code by 1.
REQ-020 SHALL latch Dwell when each code is first presented; a Dwell change takes effect from the next code.
REQ-021 SHALL wrap the scan code from 2**N-1 to 0 and assert Wrap for the one cycle in which Code = 0 is first presented after the wrap.
REQ-022 SHALL hold Wrap at 0 in direct mode and on scan entry.
REQ-023 SHALL, when Mode changes while E = 1, clear Out, Out_valid and the dwell counter on the next edge.
REQ-024 SHALL, after a 0->1 Mode change, start the scan at code 0 one cycle after the clearing cycle.
REQ-025 SHALL, with E = 0, force Out = 0 and Out_valid = 0 on the next edge while the scan code and dwell counter hold (pause).
REQ-026 SHALL, on E returning to 1 in scan mode, resume the paused code with a fresh dwell period on the next edge.
REQ-027 SHALL, on E returning to 1 in direct mode, keep Out at 0 until a new transfer occurs.
REQ-028 SHALL guarantee Out is either all-zero or exactly one-hot on every cycle, and Out_valid = 1 only when Out is one-hot.

Reset
REQ-029 SHALL, while rst = 1 at a clock edge, set Out = 0, Out_valid = 0, Code = 0, Wrap = 0, scan code = 0 and dwell counter = 0.
REQ-030 SHALL let rst override E, Mode and any transfer in the same cycle; a reset mid-dwell abandons the dwell period.
REQ-031 SHALL, on the first edge after rst falls with E = 1 and Mode = 1, present code 0.

Configuration
REQ-032 SHALL compile in, when macro DECODER_SCAN_BIDIR_EN is defined, an extra input port Dir (1 bit).
REQ-033 SHALL, with that macro defined and Dir = 1, scan downward (0 follows 1, 2**N-1 follows 0).
REQ-034 SHALL, with that macro defined, pulse Wrap when Code = 2**N-1 is first presented after a downward wrap.
REQ-035 SHALL, without that macro, have no Dir port and scan upward only.

Verification (N=3, DWELL_W=4)
REQ-036 SHALL cover direct decode: E=1, Mode=0, In=0..7 one per cycle with In_valid=1 -> Out = 8'h01, 02, 04 ... 80, each one cycle after its input, Out_valid=1.
REQ-037 SHALL cover scan timing: E=1, Mode=1, Dwell=2 -> each code held 3 cycles, 0..7 in order, Wrap=1 only on the 0 following 7 (period 24 cycles).
REQ-038 SHALL cover pause/resume: scan at Code=5, E=0 for 4 cycles -> Out=0, Out_valid=0; E=1 -> Code=5 for a full 3 cycles, then 6.
REQ-039 SHALL cover handshake gating: Mode=1 with In_valid=1, In=3 -> In_ready=0 and no direct decode; switch Mode=0 -> Out=0 for one cycle, then the transfer yields Out=8'h08.
REQ-040 SHALL cover reset mid-scan: rst=1 for one cycle at Code=6 -> Out=0, Out_valid=0, Code=0; the scan restarts at 0 with Wrap=0.
REQ-041 SHALL cover the macro (DECODER_SCAN_BIDIR_EN defined): Dir=1, Dwell=0 -> Code 0,7,6,...,1,0, with Wrap=1 when 7 appears.
